// File: rtl/lfsr_pkg.sv
// rtl/lfsr_pkg.sv - shared types, default taps and mask helper for the LFSR random generator
package lfsr_pkg;

    // Roll engine states
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STIR   = 2'd1,
        SAMPLE = 2'd2,
        DONE   = 2'd3
    } roll_state_t;

    // Maximal-length Galois feedback masks for common widths
    localparam logic [7:0]  TAPS_W8  = 8'hB8;
    localparam logic [15:0] TAPS_W16 = 16'hB400;
    localparam logic [23:0] TAPS_W24 = 24'hE10000;
    localparam logic [31:0] TAPS_W32 = 32'hA3000000;

    // Smallest 2^k-1 covering rng-1; rng==0 means the whole width is in play.
    // The OR-smear propagates the top set bit of rng-1 down to bit 0.
    function automatic logic [31:0] range_mask(input logic [31:0] rng, input int width);
        logic [31:0] m;
        if (rng == 32'd0) begin
            m = 32'hFFFF_FFFF >> (32 - width);
        end else begin
            m = rng - 32'd1;
            m = m | (m >> 1);
            m = m | (m >> 2);
            m = m | (m >> 4);
            m = m | (m >> 8);
            m = m | (m >> 16);
        end
        return m;
    endfunction

endpackage

// File: rtl/lfsr_core.sv
// rtl/lfsr_core.sv - free-running Galois LFSR with zero-safe seed load
module lfsr_core #(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = 8'hB8,
    parameter logic [WIDTH-1:0] SEED  = 8'h01
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Load,
    input  logic [WIDTH-1:0] Load_Val,
    output logic [WIDTH-1:0] State
);

    logic [WIDTH-1:0] step_val;
    logic [WIDTH-1:0] load_sel;

    // A zero seed would lock the register, so it is replaced by the default seed
    assign load_sel = (Load_Val == '0) ? SEED : Load_Val;

    // Galois step: shift right, fold the taps back in when a one drops out
    assign step_val = (State >> 1) ^ (State[0] ? TAPS : '0);

    // Load wins over stepping; otherwise advance every cycle
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            State <= SEED;
        end else if (Load) begin
            State <= load_sel;
        end else begin
            State <= step_val;
        end
    end

endmodule

// File: rtl/lfsr_random_gen.sv
// rtl/lfsr_random_gen.sv - LFSR generator with rejection-sampled bounded roll engine
module lfsr_random_gen
    import lfsr_pkg::*;
#(
    parameter int               WIDTH     = 8,
    parameter logic [WIDTH-1:0] TAPS      = 8'hB8,
    parameter logic [WIDTH-1:0] SEED      = 8'h01,
    parameter int               STEPS     = 8,
    parameter int               MAX_TRIES = 16
) (
    input  logic             Clk,
    input  logic             Rst,
    input  logic             Seed_Load,
    input  logic [WIDTH-1:0] Seed_In,
    input  logic             Req,
    input  logic [WIDTH-1:0] Range,
    output logic             Busy,
    output logic             Valid,
    output logic [WIDTH-1:0] Show_Num,
    output logic [WIDTH-1:0] Lfsr_State
);

    localparam int SCW = (STEPS > 1) ? $clog2(STEPS) : 1;
    localparam int TCW = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;
    localparam logic [SCW-1:0] STIR_LAST = SCW'(STEPS - 1);
    localparam logic [TCW-1:0] TRY_LAST  = TCW'(MAX_TRIES - 1);

    roll_state_t      state;
    logic [WIDTH-1:0] lfsr_q;
    logic [WIDTH-1:0] rng_q;
    logic [WIDTH-1:0] mask_q;
    logic [SCW-1:0]   stir_cnt;
    logic [TCW-1:0]   try_cnt;
    logic             busy_q;
    logic             valid_q;
    logic [WIDTH-1:0] show_q;
    logic [WIDTH-1:0] cand;
    logic             accept;

    lfsr_core #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED)
    ) u_core (
        .Clk      (Clk),
        .Rst      (Rst),
        .Load     (Seed_Load),
        .Load_Val (Seed_In),
        .State    (lfsr_q)
    );

    // Candidate is the masked live LFSR value; zero range accepts anything
    assign cand   = lfsr_q & mask_q;
    assign accept = (rng_q == '0) || (cand < rng_q);

    // Roll FSM: stir for STEPS cycles, then sample until accepted or out of tries.
    // The fallback halves the candidate, which always lands inside the range
    // because the mask is the tightest power-of-two cover of rng_q-1.
    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state    <= IDLE;
            rng_q    <= '0;
            mask_q   <= '0;
            stir_cnt <= '0;
            try_cnt  <= '0;
            busy_q   <= 1'b0;
            valid_q  <= 1'b0;
            show_q   <= '0;
        end else if (Seed_Load) begin
            state   <= IDLE;
            busy_q  <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    valid_q <= 1'b0;
                    if (Req) begin
                        rng_q    <= Range;
                        mask_q   <= WIDTH'(range_mask(32'(Range), WIDTH));
                        stir_cnt <= '0;
                        try_cnt  <= '0;
                        busy_q   <= 1'b1;
                        state    <= STIR;
                    end
                end
                STIR: begin
                    if (stir_cnt == STIR_LAST) begin
                        state <= SAMPLE;
                    end else begin
                        stir_cnt <= stir_cnt + 1'b1;
                    end
                end
                SAMPLE: begin
                    if (accept) begin
                        show_q  <= cand;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else if (try_cnt == TRY_LAST) begin
                        show_q  <= cand >> 1;
                        valid_q <= 1'b1;
                        state   <= DONE;
                    end else begin
                        try_cnt <= try_cnt + 1'b1;
                    end
                end
                DONE: begin
                    valid_q <= 1'b0;
                    busy_q  <= 1'b0;
                    state   <= IDLE;
                end
                default: begin
                    state   <= IDLE;
                    busy_q  <= 1'b0;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    assign Busy       = busy_q;
    assign Valid      = valid_q;
    assign Show_Num   = show_q;
    assign Lfsr_State = lfsr_q;

endmodule

// File: tb/tb_lfsr_random_gen.sv
// tb/tb_lfsr_random_gen.sv - directed self-checking bench for lfsr_random_gen
module tb_lfsr_random_gen;

    localparam int STEPS     = 8;
    localparam int MAX_TRIES = 16;

    logic       Clk;
    logic       Rst;
    logic       Seed_Load;
    logic [7:0] Seed_In;
    logic       Req;
    logic [7:0] Range;
    logic       Busy;
    logic       Valid;
    logic [7:0] Show_Num;
    logic [7:0] Lfsr_State;

    int checks = 0;
    int errors = 0;
    logic [7:0] ms;

    typedef struct {
        logic       load;
        logic [7:0] seed;
        logic [7:0] exp_state;
    } vec_t;

    vec_t vecs[10];

    lfsr_random_gen #(
        .WIDTH     (8),
        .TAPS      (8'hB8),
        .SEED      (8'h01),
        .STEPS     (STEPS),
        .MAX_TRIES (MAX_TRIES)
    ) dut (
        .Clk        (Clk),
        .Rst        (Rst),
        .Seed_Load  (Seed_Load),
        .Seed_In    (Seed_In),
        .Req        (Req),
        .Range      (Range),
        .Busy       (Busy),
        .Valid      (Valid),
        .Show_Num   (Show_Num),
        .Lfsr_State (Lfsr_State)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] step(input logic [7:0] s);
        return (s >> 1) ^ (s[0] ? 8'hB8 : 8'h00);
    endfunction

    // Independent reference for one roll started with LFSR=start in the Req cycle
    function automatic void roll_model(input logic [7:0] start, input logic [7:0] rng,
                                       output logic [7:0] val, output int lat);
        logic [7:0] s;
        logic [7:0] mask;
        logic [7:0] cand;
        bit         done;
        val  = 8'h00;
        lat  = 0;
        done = 0;
        s    = start;
        if (rng == 8'd0) begin
            mask = 8'hFF;
        end else begin
            mask = 8'h00;
            while (int'(mask) < int'(rng) - 1) mask = (mask << 1) | 8'h01;
        end
        for (int i = 0; i <= STEPS; i++) s = step(s);
        for (int tr = 0; tr < MAX_TRIES; tr++) begin
            if (!done) begin
                cand = s & mask;
                if (rng == 8'd0 || cand < rng) begin
                    val = cand; lat = STEPS + 2 + tr; done = 1;
                end else if (tr == MAX_TRIES - 1) begin
                    val = cand >> 1; lat = STEPS + 2 + tr; done = 1;
                end
                s = step(s);
            end
        end
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Advance one clock, keeping the reference LFSR in step with the driven inputs
    task automatic tick();
        logic [7:0] nxt;
        nxt = Seed_Load ? ((Seed_In == 8'h00) ? 8'h01 : Seed_In) : step(ms);
        @(posedge Clk);
        ms = nxt;
        #1;
    endtask

    task automatic do_roll(input logic [7:0] rng, output logic [7:0] val, output int lat,
                           output logic [7:0] exp_val, output int exp_lat);
        bit got;
        roll_model(ms, rng, exp_val, exp_lat);
        Req = 1'b1; Range = rng;
        tick();
        Req = 1'b0;
        got = 0; val = 8'h00; lat = 0;
        for (int k = 1; k <= 30; k++) begin
            if (!got) begin
                if (Valid) begin
                    got = 1; lat = k; val = Show_Num;
                end
                tick();
            end
        end
        if (!got) chk("roll_timeout", 32'(got), 32'd1);
    endtask

    initial begin
        logic [7:0] v, rv, ev, prev_show;
        int         lat, elat, zeros, dups, nseen, vcount, vk, worst, bad;
        bit         seen[256];
        bit         seen6[6];

        Rst = 1'b0; Seed_Load = 1'b0; Seed_In = 8'h00; Req = 1'b0; Range = 8'h00;
        ms = 8'h01;
        repeat (2) @(posedge Clk);
        #1;
        chk("reset_lfsr", 32'(Lfsr_State), 32'h01);
        chk("reset_busy", 32'(Busy), 32'd0);
        chk("reset_valid", 32'(Valid), 32'd0);
        chk("reset_show", 32'(Show_Num), 32'd0);
        Rst = 1'b1;
        ms  = 8'h01;

        vecs[0] = '{1'b0, 8'h00, 8'h01};
        vecs[1] = '{1'b0, 8'h00, 8'hB8};
        vecs[2] = '{1'b0, 8'h00, 8'h5C};
        vecs[3] = '{1'b0, 8'h00, 8'h2E};
        vecs[4] = '{1'b0, 8'h00, 8'h17};
        vecs[5] = '{1'b1, 8'h00, 8'hB3};
        vecs[6] = '{1'b1, 8'h5A, 8'h01};
        vecs[7] = '{1'b0, 8'h00, 8'h5A};
        vecs[8] = '{1'b0, 8'h00, 8'h2D};
        vecs[9] = '{1'b0, 8'h00, 8'hAE};
        for (int i = 0; i < 10; i++) begin
            chk($sformatf("vec%0d_lfsr", i), 32'(Lfsr_State), 32'(vecs[i].exp_state));
            Seed_Load = vecs[i].load;
            Seed_In   = vecs[i].seed;
            tick();
        end
        Seed_Load = 1'b0;
        chk("vec_busy_idle", 32'(Busy), 32'd0);

        // Full period from 01
        Seed_Load = 1'b1; Seed_In = 8'h00;
        tick();
        Seed_Load = 1'b0;
        zeros = 0; dups = 0; nseen = 0;
        for (int i = 0; i < 256; i++) seen[i] = 0;
        for (int i = 0; i < 255; i++) begin
            v = Lfsr_State;
            if (v == 8'h00) zeros++;
            else if (seen[v]) dups++;
            else begin seen[v] = 1; nseen++; end
            tick();
        end
        chk("period_return", 32'(Lfsr_State), 32'h01);
        chk("period_zeros", 32'(zeros), 32'd0);
        chk("period_dups", 32'(dups), 32'd0);
        chk("period_seen", 32'(nseen), 32'd255);

        // Range=0 roll, cycle by cycle
        Seed_Load = 1'b1; Seed_In = 8'h5A;
        tick();
        Seed_Load = 1'b0;
        chk("seed5a_lfsr", 32'(Lfsr_State), 32'h5A);
        tick();
        chk("seed5a_step", 32'(Lfsr_State), 32'h2D);
        roll_model(ms, 8'd0, ev, elat);
        Req = 1'b1; Range = 8'd0;
        tick();
        Req = 1'b0;
        for (int k = 1; k <= 11; k++) begin
            chk($sformatf("r0_busy_t%0d", k), 32'(Busy), 32'(k <= 10));
            chk($sformatf("r0_valid_t%0d", k), 32'(Valid), 32'(k == 10));
            if (k == 9) chk("r0_sample_lfsr", 32'(Lfsr_State), 32'(ms));
            if (k == 10) chk("r0_show", 32'(Show_Num), 32'(ev));
            tick();
        end
        chk("r0_model_lat", 32'(elat), 32'd10);

        // Req while busy is ignored
        Req = 1'b1; Range = 8'd0;
        tick();
        Req = 1'b0;
        vcount = 0; vk = 0;
        for (int k = 1; k <= 25; k++) begin
            if (Valid) begin vcount++; vk = k; end
            Req   = (k == 3);
            Range = 8'd5;
            tick();
        end
        Req = 1'b0;
        chk("busy_req_valids", 32'(vcount), 32'd1);
        chk("busy_req_time", 32'(vk), 32'd10);

        // Range=1 always returns 0 at t+10
        do_roll(8'd1, rv, lat, ev, elat);
        chk("r1_val", 32'(rv), 32'd0);
        chk("r1_lat", 32'(lat), 32'd10);

        // Range=6 bulk rolls
        worst = 0; bad = 0;
        for (int i = 0; i < 6; i++) seen6[i] = 0;
        for (int n = 0; n < 2000; n++) begin
            do_roll(8'd6, rv, lat, ev, elat);
            chk("r6_val", 32'(rv), 32'(ev));
            chk("r6_lat", 32'(lat), 32'(elat));
            if (rv < 8'd6) seen6[rv] = 1; else bad++;
            if (lat > worst) worst = lat;
        end
        chk("r6_out_of_range", 32'(bad), 32'd0);
        for (int i = 0; i < 6; i++) chk($sformatf("r6_seen_%0d", i), 32'(seen6[i]), 32'd1);
        chk("r6_worst_ok", 32'(worst <= STEPS + MAX_TRIES + 2), 32'd1);

        // Seed_Load during STIR aborts the roll
        do_roll(8'd0, rv, lat, ev, elat);
        chk("pre_abort_show", 32'(rv), 32'(ev));
        prev_show = ev;
        Req = 1'b1; Range = 8'd0;
        tick();
        Req = 1'b0;
        repeat (3) tick();
        Seed_Load = 1'b1; Seed_In = 8'h33;
        tick();
        Seed_Load = 1'b0;
        chk("abort_busy", 32'(Busy), 32'd0);
        chk("abort_lfsr", 32'(Lfsr_State), 32'h33);
        vcount = 0;
        for (int k = 0; k < 20; k++) begin
            if (Valid || Busy) vcount++;
            tick();
        end
        chk("abort_no_valid", 32'(vcount), 32'd0);
        chk("abort_show_held", 32'(Show_Num), 32'(prev_show));

        // Async reset mid-SAMPLE
        Req = 1'b1; Range = 8'd0;
        tick();
        Req = 1'b0;
        repeat (8) tick();
        chk("pre_rst_busy", 32'(Busy), 32'd1);
        #2;
        Rst = 1'b0;
        #1;
        chk("arst_lfsr", 32'(Lfsr_State), 32'h01);
        chk("arst_busy", 32'(Busy), 32'd0);
        chk("arst_valid", 32'(Valid), 32'd0);
        chk("arst_show", 32'(Show_Num), 32'd0);
        @(posedge Clk);
        #1;
        Rst = 1'b1;
        ms  = 8'h01;
        tick();
        chk("post_rst_lfsr", 32'(Lfsr_State), 32'hB8);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
